fir_decim_round_sat: RTL and testbench
======================================

// Module: fir_decim_round_sat
// PURPOSE
//  Post-FIR output stage, directly downstream of the 15-tap FIR in the AXIS chain.
//  - Takes the FIR's 32-bit signed products-sum stream.
//  - Decimates by DECIM, rounds away SHIFT LSBs, saturates to OUT_WIDTH bits.
//  - Re-emits the result as AXI-Stream with full backpressure through a 2-entry skid buffer.
// PARAMETERS
//  C_S00_AXIS_TDATA_WIDTH  32  input word width, signed two's complement
//  C_M00_AXIS_TDATA_WIDTH  32  output word width; result sign-extended into it
//  DECIM                   4   keep 1 of every DECIM accepted samples (legal 1..256)
//  SHIFT                   8   arithmetic right shift applied before saturation (0..24)
//  OUT_WIDTH               16  saturation width in bits (2..C_M00_AXIS_TDATA_WIDTH)
// PORTS
//  s00_axis_aclk    in   1     single clock for the whole block
//  s00_axis_areset  in   1     synchronous reset, active-high
//  s00_axis_tvalid  in   1     upstream data valid
//  s00_axis_tlast   in   1     upstream end-of-frame
//  s00_axis_tdata   in   32    upstream sample, signed
//  s00_axis_tready  out  1     block can accept (registered)
//  m00_axis_tready  in   1     downstream ready
//  m00_axis_tvalid  out  1     output valid
//  m00_axis_tlast   out  1     output end-of-frame
//  m00_axis_tdata   out  32    rounded/saturated sample, sign-extended from OUT_WIDTH
//  m00_axis_tstrb   out  4     constant 4'b1111
//  sat_count        out  16    saturation event counter (see CONFIGURATION)
// BEHAVIOUR
//  Interface
//  - One clock: s00_axis_aclk.
//  - Reset s00_axis_areset is synchronous, active-high.
//  - While reset is high: m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, s00_axis_tready=0.
//    Phase counter=0, skid empty, sat_count=0.
//  - s00_axis_tready=1 on the first cycle after reset deasserts.
//  - Reset mid-frame discards all buffered/partial data; no output is produced for it.
//  Handshake
//  - Input accept = tvalid & tready; output transfer = tvalid & tready. Cycles without a handshake are ignored.
//  - Output register plus one skid entry.
//  - s00_axis_tready = skid entry empty (registered, no combinational path from m00_axis_tready).
//  - Output holds tdata/tlast stable while tvalid=1 & tready=0.
//  Decimation
//  - Phase counter 0..DECIM-1 advances on every input accept.
//  - A sample is emitted when the accepted sample has phase==DECIM-1 OR tlast=1.
//  - On emit the counter returns to 0. tlast=1 therefore flushes a partial group.
//  - m00_axis_tlast = tlast of the emitted sample.
//  - DECIM=1: every accepted sample is emitted.
//  Arithmetic (33-bit signed intermediate, no overflow)
//  - r = (x + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT   (round half toward +inf).
//  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//  - Sign-extend the result to 32 bits.
//  - Saturation event = clamping occurred on an emitted sample. Dropped samples never count.
//  Latency
//  - Emitted sample accepted in cycle N appears on m00_axis_tvalid in cycle N+1 when the output is empty.
//  Full/empty
//  - Output full and m00_axis_tready=0 on an accept: the sample goes to skid; s00_axis_tready drops next cycle.
//  - When the output drains: skid moves to the output register in the same cycle; tready returns next cycle.
//  - Simultaneous output transfer and emitting accept with skid empty: new sample loads the output register; skid stays empty.
//  - Non-emitted (decimated-away) accepts never consume buffer space.
// CONFIGURATION
//  Macro: FIR_DECIM_SAT_COUNT_EN
//  - Defined: sat_count increments on each saturation event.
//    It saturates at 16'hFFFF (no wrap) and clears only on reset.
//  - Undefined: no counter logic; sat_count tied to 0.
// TESTING
//  1. DECIM=4, SHIFT=8, tready=1; inputs 256,512,768,1024 contiguous, tlast on 4th
//     -> one output 4, tlast=1, one cycle after the 4th accept.
//  2. Rounding: DECIM=1, SHIFT=8; inputs 128,127,-128,-129
//     -> outputs 1,0,0,-1.
//  3. Saturation: DECIM=1, SHIFT=0, OUT_WIDTH=16; inputs 40000,-40000,32767
//     -> 32767,-32768,32767; sat_count=2 with macro, 0 without.
//  4. Partial flush: DECIM=4; 6 samples 0x100..0x600 (SHIFT=8), tlast on 6th
//     -> outputs 4 (tlast=0) then 6 (tlast=1); counter=0 after.
//  5. Backpressure: DECIM=1, m00_axis_tready=0 for 5 cycles while streaming
//     -> exactly 2 samples buffered, s00_axis_tready=0 from the cycle after the 2nd accept;
//     on release the outputs arrive in order with no loss or duplication.
//  6. Reset asserted mid-frame with both entries full
//     -> next cycle tvalid=0 and tready=0; first post-reset frame decimates from phase 0.

Source files
------------

// File: rtl/fir_decim_round_sat.sv
// fir_decim_round_sat: output stage downstream of the 15-tap FIR.
// Decimates the accepted stream by DECIM, rounds off SHIFT LSBs (half toward
// +inf), saturates to OUT_WIDTH bits and re-emits on AXI-Stream through an
// output register plus one skid entry.
// Optional build macro FIR_DECIM_SAT_COUNT_EN enables the saturation event
// counter on sat_count; without it sat_count is tied to zero.
module fir_decim_round_sat #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int DECIM                  = 4,
   parameter int SHIFT                  = 8,
   parameter int OUT_WIDTH              = 16
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_areset,
   input  logic                                  s00_axis_tvalid,
   input  logic                                  s00_axis_tlast,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   output logic                                  s00_axis_tready,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
   output logic [15:0]                           sat_count
);

   localparam int IW = C_S00_AXIS_TDATA_WIDTH;
   localparam int OW = C_M00_AXIS_TDATA_WIDTH;
   localparam int AW = IW + 1;
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

   // Half an output LSB; zero when nothing is shifted away.
   localparam logic signed [AW-1:0] RND =
      signed'(AW'((64'd1 << SHIFT) >> 1));
   localparam logic signed [AW-1:0] SAT_MAX =
      signed'({{(AW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
   localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

   logic                  accept;
   logic                  emit;
   logic                  out_free;
   logic [PW-1:0]         phase;

   logic signed [AW-1:0]  x_ext;
   logic signed [AW-1:0]  rnd_sum;
   logic signed [AW-1:0]  shifted;
   logic signed [AW-1:0]  clamped;
   logic                  sat_hi;
   logic                  sat_lo;
   logic [OW-1:0]         result;

   logic                  tready_q;
   logic                  out_valid, out_valid_d;
   logic                  out_last, out_last_d;
   logic [OW-1:0]         out_data, out_data_d;
   logic                  skid_valid, skid_valid_d;
   logic                  skid_last, skid_last_d;
   logic [OW-1:0]         skid_data, skid_data_d;

   logic                  unused_bits;

   assign accept   = s00_axis_tvalid & tready_q;
   assign emit     = accept & ((phase == PHASE_LAST) | s00_axis_tlast);
   assign out_free = ~out_valid | m00_axis_tready;

   // Round, shift and clamp the incoming sample in a 33-bit signed domain.
   always_comb begin
      x_ext   = AW'(signed'(s00_axis_tdata));
      rnd_sum = x_ext + RND;
      shifted = rnd_sum >>> SHIFT;
      sat_hi  = (shifted > SAT_MAX);
      sat_lo  = (shifted < SAT_MIN);
      if (sat_hi)
         clamped = SAT_MAX;
      else if (sat_lo)
         clamped = SAT_MIN;
      else
         clamped = shifted;
      result  = OW'(clamped);
   end

   // Clamped value is within OUT_WIDTH bits, so its upper bits are redundant.
   assign unused_bits = ^clamped;

   // Phase counter: advances per accept, returns to 0 on every emit.
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset)
         phase <= '0;
      else if (accept)
         phase <= emit ? '0 : phase + PW'(1);
   end

   // Next state for output register and skid entry.
   // Accepts only happen while the skid is empty, so a pending skid word and
   // a new emit never compete for the output register.
   always_comb begin
      out_valid_d  = out_valid;
      out_last_d   = out_last;
      out_data_d   = out_data;
      skid_valid_d = skid_valid;
      skid_last_d  = skid_last;
      skid_data_d  = skid_data;
      if (out_free) begin
         if (skid_valid) begin
            out_valid_d  = 1'b1;
            out_last_d   = skid_last;
            out_data_d   = skid_data;
            skid_valid_d = 1'b0;
         end else if (emit) begin
            out_valid_d  = 1'b1;
            out_last_d   = s00_axis_tlast;
            out_data_d   = result;
         end else begin
            out_valid_d  = 1'b0;
         end
      end else if (emit) begin
         skid_valid_d = 1'b1;
         skid_last_d  = s00_axis_tlast;
         skid_data_d  = result;
      end
   end

   // Buffer registers; tready is the registered "skid will be empty" flag.
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_last  <= 1'b0;
         skid_data  <= '0;
         tready_q   <= 1'b0;
      end else begin
         out_valid  <= out_valid_d;
         out_last   <= out_last_d;
         out_data   <= out_data_d;
         skid_valid <= skid_valid_d;
         skid_last  <= skid_last_d;
         skid_data  <= skid_data_d;
         tready_q   <= ~skid_valid_d;
      end
   end

   assign s00_axis_tready = tready_q;
   assign m00_axis_tvalid = out_valid;
   assign m00_axis_tlast  = out_last;
   assign m00_axis_tdata  = out_data;
   assign m00_axis_tstrb  = '1;

`ifdef FIR_DECIM_SAT_COUNT_EN
   // Count clamps on emitted samples only; sticks at all-ones.
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset)
         sat_count <= '0;
      else if (emit && (sat_hi || sat_lo) && (sat_count != 16'hFFFF))
         sat_count <= sat_count + 16'd1;
   end
`else
   assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_decim_round_sat.sv
// Scoreboard bench for fir_decim_round_sat: three instances with different
// decimation/shift settings, directed vectors, expected words queued at issue
// and checked by an independent output monitor.
module tb_fir_decim_round_sat;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        s_tvalid [3];
   logic        s_tlast  [3];
   logic [31:0] s_tdata  [3];
   logic        s_tready [3];
   logic        m_tready [3];
   logic        m_tvalid [3];
   logic        m_tlast  [3];
   logic [31:0] m_tdata  [3];
   logic [3:0]  m_tstrb  [3];
   logic [15:0] sat_cnt  [3];

   fir_decim_round_sat #(.DECIM(4), .SHIFT(8), .OUT_WIDTH(16)) u_d4 (
      .s00_axis_aclk(clk), .s00_axis_areset(rst),
      .s00_axis_tvalid(s_tvalid[0]), .s00_axis_tlast(s_tlast[0]),
      .s00_axis_tdata(s_tdata[0]), .s00_axis_tready(s_tready[0]),
      .m00_axis_tready(m_tready[0]), .m00_axis_tvalid(m_tvalid[0]),
      .m00_axis_tlast(m_tlast[0]), .m00_axis_tdata(m_tdata[0]),
      .m00_axis_tstrb(m_tstrb[0]), .sat_count(sat_cnt[0]));

   fir_decim_round_sat #(.DECIM(1), .SHIFT(8), .OUT_WIDTH(16)) u_d1s8 (
      .s00_axis_aclk(clk), .s00_axis_areset(rst),
      .s00_axis_tvalid(s_tvalid[1]), .s00_axis_tlast(s_tlast[1]),
      .s00_axis_tdata(s_tdata[1]), .s00_axis_tready(s_tready[1]),
      .m00_axis_tready(m_tready[1]), .m00_axis_tvalid(m_tvalid[1]),
      .m00_axis_tlast(m_tlast[1]), .m00_axis_tdata(m_tdata[1]),
      .m00_axis_tstrb(m_tstrb[1]), .sat_count(sat_cnt[1]));

   fir_decim_round_sat #(.DECIM(1), .SHIFT(0), .OUT_WIDTH(16)) u_d1s0 (
      .s00_axis_aclk(clk), .s00_axis_areset(rst),
      .s00_axis_tvalid(s_tvalid[2]), .s00_axis_tlast(s_tlast[2]),
      .s00_axis_tdata(s_tdata[2]), .s00_axis_tready(s_tready[2]),
      .m00_axis_tready(m_tready[2]), .m00_axis_tvalid(m_tvalid[2]),
      .m00_axis_tlast(m_tlast[2]), .m00_axis_tdata(m_tdata[2]),
      .m00_axis_tstrb(m_tstrb[2]), .sat_count(sat_cnt[2]));

   // Expected words: {tlast, tdata}
   logic [32:0] q0[$];
   logic [32:0] q1[$];
   logic [32:0] q2[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [32:0] act,
                        input logic [32:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int i, input logic [32:0] e);
      case (i)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Drive one beat and hold it until the DUT takes it; returns at posedge+1.
   task automatic send(input int i, input logic [31:0] d, input logic l);
      int k;
      s_tvalid[i] = 1'b1;
      s_tdata[i]  = d;
      s_tlast[i]  = l;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (s_tready[i]) break;
      end
      if (k == 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL send%0d_timeout: got tready=0 expected 1", i);
      end
      @(posedge clk);
      #1;
      s_tvalid[i] = 1'b0;
      s_tlast[i]  = 1'b0;
   endtask

   task automatic sendx(input int i, input logic [31:0] d, input logic l,
                        input logic [31:0] exp);
      push_exp(i, {l, exp});
      send(i, d, l);
   endtask

   task automatic wait_drain();
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      end
      if (k == 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d/%0d/%0d pending expected 0",
                  q0.size(), q1.size(), q2.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: every output transfer pops and checks the matching queue.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (m_tvalid[i] && m_tready[i]) begin
            logic [32:0] e;
            bit          have;
            have = 1'b0;
            e    = '0;
            case (i)
               0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (have) begin
               check($sformatf("out%0d", i), {m_tlast[i], m_tdata[i]}, e);
            end else begin
               n_cmp++;
               n_err++;
               $display("FAIL out%0d_unexpected: got %h expected none",
                        i, {m_tlast[i], m_tdata[i]});
            end
         end
      end
   end

   initial begin
      logic [15:0] exp_sat;
      logic        rdy_hist [5];
      int          acc;

`ifdef FIR_DECIM_SAT_COUNT_EN
      exp_sat = 16'd2;
`else
      exp_sat = 16'd0;
`endif

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_tvalid[i] = 1'b0;
         s_tlast[i]  = 1'b0;
         s_tdata[i]  = '0;
         m_tready[i] = 1'b1;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_tvalid%0d", i), 33'(m_tvalid[i]), 33'd0);
         check($sformatf("rst_tready%0d", i), 33'(s_tready[i]), 33'd0);
         check($sformatf("rst_tdata%0d", i), 33'(m_tdata[i]), 33'd0);
         check($sformatf("rst_satcnt%0d", i), 33'(sat_cnt[i]), 33'd0);
      end
      check("tstrb", 33'(m_tstrb[0]), 33'hF);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         check($sformatf("post_rst_tready%0d", i), 33'(s_tready[i]), 33'd1);
      @(posedge clk);
      #1;

      // 1: DECIM=4, one output of 4 with tlast, one cycle after 4th accept
      send(0, 32'd256, 1'b0);
      send(0, 32'd512, 1'b0);
      send(0, 32'd768, 1'b0);
      sendx(0, 32'd1024, 1'b1, 32'd4);
      @(negedge clk);
      check("t1_latency_tvalid", 33'(m_tvalid[0]), 33'd1);
      @(posedge clk);
      #1;

      // 2: rounding half toward +inf
      sendx(1, 32'd128, 1'b0, 32'd1);
      sendx(1, 32'd127, 1'b0, 32'd0);
      sendx(1, 32'hFFFF_FF80, 1'b0, 32'd0);
      sendx(1, 32'hFFFF_FF7F, 1'b0, 32'hFFFF_FFFF);

      // 3: saturation to 16 bits
      sendx(2, 32'd40000, 1'b0, 32'h0000_7FFF);
      sendx(2, 32'hFFFF_63C0, 1'b0, 32'hFFFF_8000);
      sendx(2, 32'd32767, 1'b0, 32'h0000_7FFF);
      wait_drain();
      check("t3_sat_count", 33'(sat_cnt[2]), 33'(exp_sat));

      // 4: partial group flushed by tlast, then phase restarts at 0
      send(0, 32'h100, 1'b0);
      send(0, 32'h200, 1'b0);
      send(0, 32'h300, 1'b0);
      sendx(0, 32'h400, 1'b0, 32'd4);
      send(0, 32'h500, 1'b0);
      sendx(0, 32'h600, 1'b1, 32'd6);
      send(0, 32'h100, 1'b0);
      send(0, 32'h200, 1'b0);
      send(0, 32'h300, 1'b0);
      sendx(0, 32'h400, 1'b1, 32'd4);
      wait_drain();

      // 5: backpressure, exactly two entries absorbed
      m_tready[1] = 1'b0;
      acc = 0;
      s_tvalid[1] = 1'b1;
      s_tlast[1]  = 1'b0;
      s_tdata[1]  = 32'h100;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         rdy_hist[c] = s_tready[1];
         if (s_tready[1]) begin
            acc++;
            push_exp(1, {1'b0, 32'(acc)});
         end
         @(posedge clk);
         #1;
         s_tdata[1] = 32'h100 * (acc + 1);
      end
      check("t5_accepts", 33'(acc), 33'd2);
      check("t5_tready_2nd_cycle", 33'(rdy_hist[1]), 33'd1);
      check("t5_tready_after_2nd", 33'(rdy_hist[2]), 33'd0);
      check("t5_hold", {m_tvalid[1], m_tdata[1]}, {1'b1, 32'd1});
      s_tvalid[1] = 1'b0;
      m_tready[1] = 1'b1;
      for (int k = acc + 1; k <= 5; k++)
         sendx(1, 32'h100 * k, 1'b0, 32'(k));
      wait_drain();

      // 6: reset with both entries full discards everything
      m_tready[0] = 1'b0;
      for (int k = 1; k <= 8; k++)
         send(0, 32'h1000 * k, 1'b0);
      @(negedge clk);
      check("t6_full_tready", 33'(s_tready[0]), 33'd0);
      check("t6_hold", {m_tlast[0], m_tdata[0]}, {1'b0, 32'h40});
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_rst_tvalid", 33'(m_tvalid[0]), 33'd0);
      check("t6_rst_tready", 33'(s_tready[0]), 33'd0);
      check("t6_rst_satcnt", 33'(sat_cnt[2]), 33'd0);
      rst = 1'b0;
      m_tready[0] = 1'b1;
      // partial group then reset: the next frame must still start at phase 0
      send(0, 32'h100, 1'b0);
      send(0, 32'h200, 1'b0);
      pulse_reset();
      send(0, 32'h100, 1'b0);
      send(0, 32'h200, 1'b0);
      send(0, 32'h300, 1'b0);
      sendx(0, 32'h400, 1'b1, 32'd4);
      wait_drain();
      repeat (5) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
